// File: rtl/gal_olmc_bank_pkg.sv
// -----------------------------------------------------------------------------
// gal_olmc_bank_pkg
// Shared GAL output-macrocell definitions: the maximum bank width, the
// mode-mask constants used when describing a device, and small helpers that
// extract a per-cell mode bit from a full-width mask.
// -----------------------------------------------------------------------------
package gal_olmc_bank_pkg;

  // Largest number of output macrocells a bank may hold.
  localparam int unsigned GAL_MAX_WIDTH = 16;

  // Mode masks are always carried at full device width; bits above the
  // instantiated width are simply never looked at.
  typedef logic [GAL_MAX_WIDTH-1:0] gal_mask_t;

  localparam gal_mask_t GAL_MASK_NONE = 16'h0000;
  localparam gal_mask_t GAL_MASK_ALL  = 16'hFFFF;

  // Storage mode of a single macrocell.
  typedef enum logic [0:0] {
    CELL_COMB = 1'b0,
    CELL_REG  = 1'b1
  } cell_mode_e;

  // Source of the feedback path for a combinational macrocell.
  typedef enum logic [0:0] {
    FB_INTERNAL = 1'b0,
    FB_PIN      = 1'b1
  } fb_src_e;

  // Pick one bit out of a mode mask; positions beyond the device width
  // read as zero rather than wrapping.
  function automatic logic mask_bit(input gal_mask_t mask, input int unsigned idx);
    logic [3:0] sel;
    sel = idx[3:0];
    if (idx < GAL_MAX_WIDTH) begin
      return mask[sel];
    end else begin
      return 1'b0;
    end
  endfunction

  // Translate a REGISTERED mask bit into a cell mode.
  function automatic cell_mode_e mode_of(input logic reg_bit);
    if (reg_bit) begin
      return CELL_REG;
    end else begin
      return CELL_COMB;
    end
  endfunction

  // Translate a FEEDBACK_PIN mask bit into a feedback source.
  function automatic fb_src_e fb_of(input logic fb_bit);
    if (fb_bit) begin
      return FB_PIN;
    end else begin
      return FB_INTERNAL;
    end
  endfunction

endpackage : gal_olmc_bank_pkg

// File: rtl/gal_olmc_bank_cell.sv
// -----------------------------------------------------------------------------
// gal_olmc_bank_cell
// One GAL output logic macrocell.
//   c_i   : clock, rising edge
//   r_i   : synchronous active-high reset (registered state only)
//   sp_i  : synchronous preset product term
//   pl_i  : preload strobe
//   pd_i  : preload data bit
//   e_i   : output enable for the pin
//   a_i   : sum-term (OR-array) result feeding this cell
//   y_io  : bidirectional pin, high-impedance when e_i is low
//   f_o   : feedback into the AND array
// A registered cell stores a_i (or preset/preload) in q_q; a combinational
// cell passes a_i straight through and keeps q_q parked at zero.
// -----------------------------------------------------------------------------
module gal_olmc_bank_cell
  import gal_olmc_bank_pkg::*;
#(
  parameter bit REGISTERED   = 1'b0,
  parameter bit INVERTED     = 1'b0,
  parameter bit FEEDBACK_PIN = 1'b0
) (
  input  logic c_i,
  input  logic r_i,
  input  logic sp_i,
  input  logic pl_i,
  input  logic pd_i,
  input  logic e_i,
  input  logic a_i,
  inout  wire  y_io,
  output logic f_o
);

  localparam cell_mode_e MODE   = mode_of(REGISTERED);
  localparam fb_src_e    FB_SRC = fb_of(FEEDBACK_PIN);

  logic q_q;
  logic q_d;
  logic int_val_s;
  logic f_s;

  // Next-state selection: reset beats preload beats preset beats the sum term.
  always_comb begin
    q_d = 1'b0;
    case (MODE)
      CELL_REG: begin
        if (r_i) begin
          q_d = 1'b0;
        end else if (pl_i) begin
          q_d = pd_i;
        end else if (sp_i) begin
          q_d = 1'b1;
        end else begin
          q_d = a_i;
        end
      end
      CELL_COMB: begin
        q_d = 1'b0;
      end
      default: begin
        q_d = 1'b0;
      end
    endcase
  end

  // State bit; no power-up value, the first reset edge defines it.
  always_ff @(posedge c_i) begin
    q_q <= q_d;
  end

  // Internal node: registered cells drive from q, combinational cells from
  // the sum term with no added latency. Polarity is applied here only, so
  // the registered feedback below stays un-inverted.
  always_comb begin
    int_val_s = 1'b0;
    case (MODE)
      CELL_REG:  int_val_s = q_q ^ INVERTED;
      CELL_COMB: int_val_s = a_i ^ INVERTED;
      default:   int_val_s = 1'b0;
    endcase
  end

  // Pin driver, enabled straight from e_i without registering.
  assign y_io = e_i ? int_val_s : 1'bz;

  // Feedback selection. Reading the pin lets a disabled cell act as an input.
  always_comb begin
    f_s = 1'b0;
    case (MODE)
      CELL_REG: begin
        f_s = q_q;
      end
      CELL_COMB: begin
        if (FB_SRC == FB_PIN) begin
          f_s = y_io;
        end else begin
          f_s = int_val_s;
        end
      end
      default: begin
        f_s = 1'b0;
      end
    endcase
  end

  assign f_o = f_s;

endmodule : gal_olmc_bank_cell

// File: rtl/gal_olmc_bank.sv
// -----------------------------------------------------------------------------
// gal_olmc_bank
// Bank of WIDTH GAL output logic macrocells sharing one clock, reset,
// synchronous preset and preload strobe.
//   c_i   : clock, rising edge
//   r_i   : synchronous active-high reset
//   sp_i  : shared synchronous preset product term (registered cells only)
//   pl_i  : shared preload strobe (registered cells only)
//   pd_i  : per-cell preload data
//   e_i   : per-cell output enable
//   a_i   : per-cell sum-term result
//   y_io  : per-cell bidirectional pin
//   f_o   : per-cell feedback into the AND array
// Mode masks are full device width; only bits [WIDTH-1:0] are used.
// -----------------------------------------------------------------------------
module gal_olmc_bank
  import gal_olmc_bank_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter gal_mask_t   REGISTERED   = GAL_MASK_NONE,
  parameter gal_mask_t   INVERTED     = GAL_MASK_NONE,
  parameter gal_mask_t   FEEDBACK_PIN = GAL_MASK_NONE
) (
  input  logic             c_i,
  input  logic             r_i,
  input  logic             sp_i,
  input  logic             pl_i,
  input  logic [WIDTH-1:0] pd_i,
  input  logic [WIDTH-1:0] e_i,
  input  logic [WIDTH-1:0] a_i,
  inout  wire  [WIDTH-1:0] y_io,
  output logic [WIDTH-1:0] f_o
);

  // One macrocell per output; each receives its own scalar mode bits.
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    gal_olmc_bank_cell #(
      .REGISTERED   (mask_bit(REGISTERED,   g)),
      .INVERTED     (mask_bit(INVERTED,     g)),
      .FEEDBACK_PIN (mask_bit(FEEDBACK_PIN, g))
    ) u_cell (
      .c_i  (c_i),
      .r_i  (r_i),
      .sp_i (sp_i),
      .pl_i (pl_i),
      .pd_i (pd_i[g]),
      .e_i  (e_i[g]),
      .a_i  (a_i[g]),
      .y_io (y_io[g]),
      .f_o  (f_o[g])
    );
  end

endmodule : gal_olmc_bank
